// File: rtl/a2d_scanner.sv
// rtl/a2d_scanner.sv - round-robin A2D channel scanner with per-channel averaging
// Drives the A2D SPI request handshake and keeps the latest channel averages readable.
module a2d_scanner #(
  parameter int NUM_CH   = 8,
  parameter int AVG_LOG2 = 2,
  parameter int GAP      = 16,
  parameter int TMO      = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        strt_cnv,
  output logic [2:0]  chnnl,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  input  logic [2:0]  rd_chnnl,
  output logic [11:0] rd_data,
  output logic        scan_done,
  output logic        vld,
  output logic        err
);

  localparam int              ACC_W    = 12 + AVG_LOG2;
  localparam int              TW       = $clog2(TMO + 1);
  localparam logic [2:0]      LAST_CH  = 3'(NUM_CH - 1);
  localparam logic [4:0]      LAST_SMP = 5'((1 << AVG_LOG2) - 1);
  localparam logic [TW-1:0]   TMO_HIT  = TW'(TMO - 2);
  localparam logic [15:0]     GAP_LD   = 16'(GAP);
  localparam logic [7:0]      LOW_MASK = 8'((1 << (NUM_CH - 1)) - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT, ACCUM, NEXT, HOLD} state_t;

  state_t           state;
  logic [2:0]       chan;
  logic [4:0]       smp;
  logic [ACC_W-1:0] acc;
  logic [15:0]      gap_cnt;
  logic [TW-1:0]    tmo_cnt;
  logic [7:0]       stored;
  logic [11:0]      regs [8];

  assign chnnl = chan;

  // strt_cnv is raised on every transition into START, so it is high exactly while in START.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      strt_cnv  <= 1'b0;
      scan_done <= 1'b0;
      vld       <= 1'b0;
      err       <= 1'b0;
      rd_data   <= '0;
      chan      <= '0;
      smp       <= '0;
      acc       <= '0;
      gap_cnt   <= '0;
      tmo_cnt   <= '0;
      stored    <= '0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      strt_cnv  <= 1'b0;
      scan_done <= 1'b0;
      rd_data   <= (rd_chnnl <= LAST_CH) ? regs[rd_chnnl] : '0;
      case (state)
        IDLE: begin
          if (en) begin
            chan     <= '0;
            strt_cnv <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          tmo_cnt <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          if (cnv_cmplt) begin
            acc   <= acc + ACC_W'(res);
            state <= ACCUM;
          end else if (tmo_cnt == TMO_HIT) begin
            err       <= 1'b1;
            acc       <= '0;
            smp       <= '0;
            scan_done <= (chan == LAST_CH);
            state     <= NEXT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ACCUM: begin
          if (smp != LAST_SMP) begin
            if (en) begin
              smp      <= smp + 1'b1;
              strt_cnv <= 1'b1;
              state    <= START;
            end else begin
              acc   <= '0;
              smp   <= '0;
              state <= IDLE;
            end
          end else begin
            regs[chan]   <= acc[AVG_LOG2 +: 12];
            acc          <= '0;
            smp          <= '0;
            stored[chan] <= 1'b1;
            if (chan == LAST_CH && (stored & LOW_MASK) == LOW_MASK) vld <= 1'b1;
            scan_done    <= (chan == LAST_CH);
            state        <= NEXT;
          end
        end
        NEXT: begin
          if (!en) begin
            state <= IDLE;
          end else if (chan != LAST_CH) begin
            chan     <= chan + 1'b1;
            strt_cnv <= 1'b1;
            state    <= START;
          end else begin
            chan    <= '0;
            gap_cnt <= GAP_LD;
            state   <= HOLD;
          end
        end
        HOLD: begin
          if (!en) begin
            state <= IDLE;
          end else if (gap_cnt <= 16'd1) begin
            gap_cnt  <= '0;
            strt_cnv <= 1'b1;
            state    <= START;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_scanner.sv
// tb/tb_a2d_scanner.sv - randomized self-checking bench for a2d_scanner
// Two instances: 8ch/avg4/gap16/tmo64 and 4ch/avg1/gap0/tmo16, each with an A2D responder.
module tb_a2d_scanner;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic a_en = 0, a_strt, a_cmplt = 0, a_sd, a_vld, a_err;
  logic [2:0] a_chnnl, a_rd = 0;
  logic [11:0] a_res = 0, a_rd_data;
  logic b_en = 0, b_strt, b_cmplt = 0, b_sd, b_vld, b_err;
  logic [2:0] b_chnnl, b_rd = 0;
  logic [11:0] b_res = 0, b_rd_data;

  a2d_scanner #(.NUM_CH(8), .AVG_LOG2(2), .GAP(16), .TMO(64)) u_a (
    .clk(clk), .rst_n(rst_n), .en(a_en), .strt_cnv(a_strt), .chnnl(a_chnnl),
    .cnv_cmplt(a_cmplt), .res(a_res), .rd_chnnl(a_rd), .rd_data(a_rd_data),
    .scan_done(a_sd), .vld(a_vld), .err(a_err));

  a2d_scanner #(.NUM_CH(4), .AVG_LOG2(0), .GAP(0), .TMO(16)) u_b (
    .clk(clk), .rst_n(rst_n), .en(b_en), .strt_cnv(b_strt), .chnnl(b_chnnl),
    .cnv_cmplt(b_cmplt), .res(b_res), .rd_chnnl(b_rd), .rd_data(b_rd_data),
    .scan_done(b_sd), .vld(b_vld), .err(b_err));

  int n_run = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  // Reference model: a channel's entry becomes the truncated mean once it has collected
  // a full set of uninterrupted samples.
  int a_sum[8], a_n[8], a_exp[8];
  int b_exp[4];
  int det_tab[4] = '{100, 200, 300, 401};
  int a_det = 0, a_hold_ch = -1, a_lat_fixed = 0, a_epoch = 0, a_last7 = 0;

  task automatic a_push(input int ch, input int r);
    a_sum[ch] += r;
    a_n[ch]++;
    if (a_n[ch] == 4) begin
      a_exp[ch] = a_sum[ch] / 4;
      a_sum[ch] = 0;
      a_n[ch]   = 0;
    end
  endtask

  task automatic a_clear_partial;
    for (int i = 0; i < 8; i++) begin
      a_sum[i] = 0;
      a_n[i]   = 0;
    end
  endtask

  initial begin : resp_a
    int ch, ep, lat, r;
    forever begin
      @(posedge clk);
      #1;
      if (a_strt && rst_n) begin
        ch = a_chnnl;
        ep = a_epoch;
        if (ch != a_hold_ch) begin
          lat = (a_lat_fixed > 0) ? a_lat_fixed : $urandom_range(1, 5);
          if (a_det == 1 && ch == 0) r = det_tab[a_n[0]];
          else if (a_det == 1 && ch == 1) r = 4095;
          else r = $urandom_range(0, 4095);
          repeat (lat) @(posedge clk);
          #1;
          a_cmplt = 1'b1;
          a_res   = 12'(r);
          if (ep == a_epoch) a_push(ch, r);
          if (ch == 7) a_last7 = cyc;
          @(posedge clk);
          #1;
          a_cmplt = 1'b0;
        end
      end
    end
  end

  initial begin : resp_b
    int ch, lat, r;
    forever begin
      @(posedge clk);
      #1;
      if (b_strt && rst_n) begin
        ch  = b_chnnl;
        lat = $urandom_range(1, 3);
        r   = $urandom_range(0, 4095);
        repeat (lat) @(posedge clk);
        #1;
        b_cmplt  = 1'b1;
        b_res    = 12'(r);
        b_exp[ch] = r;
        @(posedge clk);
        #1;
        b_cmplt = 1'b0;
      end
    end
  end

  int a_strt_q[$], a_strt_cyc[$], b_strt_q[$], b_strt_cyc[$];
  int a_sd_cnt = 0, a_sd_cyc = 0, b_sd_cnt = 0, b_sd_cyc = 0;
  int a_prev = -10, b_prev = -10, a_viol = 0, b_viol = 0;
  int a_vld_seen = 0, a_vld_cyc = 0;

  initial begin : mon
    forever begin
      @(posedge clk);
      #1;
      if (a_strt) begin
        a_strt_q.push_back(int'(a_chnnl));
        a_strt_cyc.push_back(cyc);
        if (cyc - a_prev < 2) a_viol++;
        a_prev = cyc;
      end
      if (b_strt) begin
        b_strt_q.push_back(int'(b_chnnl));
        b_strt_cyc.push_back(cyc);
        if (cyc - b_prev < 2) b_viol++;
        b_prev = cyc;
      end
      if (a_sd) begin a_sd_cnt++; a_sd_cyc = cyc; end
      if (b_sd) begin b_sd_cnt++; b_sd_cyc = cyc; end
      if (a_vld && a_vld_seen == 0) begin a_vld_seen = 1; a_vld_cyc = cyc; end
    end
  end

  task automatic a_wait_sd(input string tag);
    int s = a_sd_cnt;
    int k = 0;
    while (a_sd_cnt == s && k < 3000) begin tick; k++; end
    check(tag, a_sd_cnt - s, 1);
  endtask

  task automatic b_wait_sd(input string tag);
    int s = b_sd_cnt;
    int k = 0;
    while (b_sd_cnt == s && k < 3000) begin tick; k++; end
    check(tag, b_sd_cnt - s, 1);
  endtask

  task automatic a_wait_strt(input string tag, input int ch);
    int k = 0;
    while (!(a_strt && int'(a_chnnl) == ch) && k < 3000) begin tick; k++; end
    check(tag, k < 3000, 1);
  endtask

  task automatic a_wait_new_strt(input string tag, input int nq);
    int k = 0;
    while (a_strt_q.size() <= nq && k < 3000) begin tick; k++; end
    check(tag, a_strt_q.size() > nq, 1);
  endtask

  task automatic a_check_entries(input string tag);
    for (int i = 0; i < 8; i++) begin
      a_rd = 3'(i);
      tick;
      check(tag, a_rd_data, a_exp[i]);
    end
  endtask

  initial begin : main
    int nq, c, k, old_v, new_v;
    logic [11:0] got [8];
    repeat (3) tick;
    check("rst_strt", a_strt, 0);
    check("rst_chnnl", a_chnnl, 0);
    check("rst_sd_vld_err", {a_sd, a_vld, a_err}, 0);
    check("rst_rd_data", a_rd_data, 0);
    rst_n = 1'b1;
    tick;

    // Scan 1: fixed values on ch0/ch1, random elsewhere.
    a_det = 1;
    a_en = 1'b1;
    a_wait_sd("a_scan1_done");
    a_det = 0;
    a_lat_fixed = 12;
    check("a_sd_after_cmplt", a_sd_cyc - a_last7, 2);
    check("a_vld_with_sd", a_vld_cyc, a_sd_cyc);
    check("a_strt_count", a_strt_q.size(), 32);
    for (int i = 0; i < 32 && i < a_strt_q.size(); i++) check("a_chnnl_order", a_strt_q[i], i / 4);
    for (int i = 0; i < 8; i++) begin
      a_rd = 3'(i);
      tick;
      got[i] = a_rd_data;
    end
    check("a_entry0_avg", got[0], 250);
    check("a_entry1_full", got[1], 4095);
    for (int i = 2; i < 8; i++) check("a_entry_rand", got[i], a_exp[i]);
    a_wait_new_strt("a_next_scan", 32);
    check("a_gap_len", a_strt_cyc[32] - a_sd_cyc, 17);
    check("a_gap_chnnl0", a_strt_q[32], 0);

    // Asynchronous reset in the middle of WAIT, then a stray completion pulse.
    a_rd = 3'd1;
    while (cyc < a_strt_cyc[32] + 4) tick;
    a_epoch++;
    a_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_outputs", {a_strt, a_chnnl, a_sd, a_vld, a_err}, 0);
    check("arst_rd_data", a_rd_data, 0);
    for (int i = 0; i < 8; i++) a_exp[i] = 0;
    a_clear_partial();
    a_vld_seen = 0;
    repeat (2) tick;
    rst_n = 1'b1;
    nq = a_strt_q.size();
    repeat (20) tick;
    check("arst_no_strt", a_strt_q.size(), nq);
    check("arst_vld", a_vld, 0);
    a_check_entries("arst_entry");
    a_lat_fixed = 0;

    // Timeout on channel 3.
    a_hold_ch = 3;
    a_en = 1'b1;
    a_wait_strt("a_tmo_strt3", 3);
    c = cyc;
    while (cyc < c + 32) tick;
    check("a_err_early", a_err, 0);
    while (cyc < c + 64) tick;
    check("a_err_set", a_err, 1);
    nq = a_strt_q.size();
    a_wait_new_strt("a_tmo_skip", nq);
    check("a_tmo_next_ch", a_strt_q[nq], 4);
    a_hold_ch = -1;
    a_wait_sd("a_tmo_scan_done");
    check("a_tmo_vld_low", a_vld, 0);
    a_check_entries("a_tmo_entry");

    // Drop en during WAIT of channel 5, sample 2.
    k = 0;
    c = 0;
    while (c < 3 && k < 3000) begin
      tick;
      k++;
      if (a_strt && a_chnnl == 3'd5) c++;
    end
    check("a_ch5_s2_seen", c, 3);
    tick;
    a_en = 1'b0;
    nq = a_strt_q.size();
    repeat (30) tick;
    check("a_en_stop", a_strt_q.size(), nq);
    a_clear_partial();
    a_check_entries("a_en_entry");
    check("a_en_vld_low", a_vld, 0);
    a_en = 1'b1;
    nq = a_strt_q.size();
    a_wait_new_strt("a_reen_strt", nq);
    check("a_reen_chnnl", a_strt_q[nq], 0);
    a_wait_sd("a_reen_done");
    check("a_reen_vld", a_vld, 1);
    check("a_err_sticky", a_err, 1);
    a_check_entries("a_reen_entry");
    a_en = 1'b0;

    // Instance B: GAP=0, out-of-range read, read/write collision.
    b_en = 1'b1;
    b_wait_sd("b_scan1_done");
    nq = b_strt_q.size();
    k = 0;
    while (b_strt_q.size() <= nq && k < 100) begin tick; k++; end
    check("b_gap0_seen", b_strt_q.size() > nq, 1);
    if (b_strt_q.size() > nq) begin
      check("b_gap0_len", b_strt_cyc[nq] - b_sd_cyc, 2);
      check("b_gap0_chnnl", b_strt_q[nq], 0);
    end
    b_wait_sd("b_scan2_done");
    b_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_rd = 3'(i);
      tick;
      check("b_entry", b_rd_data, b_exp[i]);
    end
    b_rd = 3'd7;
    tick;
    check("b_rd_oob7", b_rd_data, 0);
    b_rd = 3'd4;
    tick;
    check("b_rd_oob4", b_rd_data, 0);
    b_rd = 3'd2;
    b_en = 1'b1;
    k = 0;
    while (!(b_strt && b_chnnl == 3'd2) && k < 200) begin tick; k++; end
    old_v = b_exp[2];
    k = 0;
    while (!b_cmplt && k < 50) begin tick; k++; end
    check("b_coll_cmplt", b_cmplt, 1);
    new_v = int'(b_res);
    tick;
    tick;
    check("b_coll_old", b_rd_data, old_v);
    tick;
    check("b_coll_new", b_rd_data, new_v);
    b_en = 1'b0;
    check("b_err_clear", b_err, 0);
    repeat (10) tick;

    check("a_strt_spacing", a_viol, 0);
    check("b_strt_spacing", b_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
